// File: rtl/axi_burst_writer.sv
// axi_burst_writer: single-outstanding INCR AXI4 write master.
// Issues AW, then the W beats with WLAST on the final one, then waits for B and reports BRESP.
module axi_burst_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESTN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_REJ} state_t;

    state_t     r_state, w_next;
    logic       r_live;
    logic [8:0] r_loaded;
    logic       w_cmd_hs, w_data_hs, w_beat_ret, w_last_ret;

    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_cmd_hs ? ((cmd_size > MAX_SIZE) ? S_REJ : S_ADDR) : S_IDLE;
            S_ADDR:  w_next = AWREADY ? S_DATA : S_ADDR;
            S_DATA:  w_next = w_last_ret ? S_RESP : S_DATA;
            S_RESP:  w_next = BVALID ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // r_live keeps cmd_ready low until the first edge after reset release
    always_comb begin
        cmd_ready     = r_live && (r_state == S_IDLE);
        wr_data_ready = (r_state == S_DATA) && (r_loaded <= {1'b0, AWLEN}) && (!WVALID || WREADY);
        w_cmd_hs      = cmd_valid && cmd_ready;
        w_data_hs     = wr_data_valid && wr_data_ready;
        w_beat_ret    = (r_state == S_DATA) && WVALID && WREADY;
        w_last_ret    = w_beat_ret && WLAST;
    end

    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) begin
            r_live     <= 1'b0;
            r_loaded   <= '0;
            AWADDR     <= '0;
            AWLEN      <= '0;
            AWSIZE     <= '0;
            AWVALID    <= 1'b0;
            WDATA      <= '0;
            WLAST      <= 1'b0;
            WVALID     <= 1'b0;
            BREADY     <= 1'b0;
            done_valid <= 1'b0;
            done_resp  <= '0;
        end else begin
            r_live     <= 1'b1;
            done_valid <= 1'b0;
            if (r_state == S_IDLE && w_cmd_hs) begin
                if (cmd_size > MAX_SIZE) begin
                    done_valid <= 1'b1;
                    done_resp  <= 2'b10;
                end else begin
                    AWADDR   <= cmd_addr;
                    AWLEN    <= cmd_len;
                    AWSIZE   <= cmd_size;
                    AWVALID  <= 1'b1;
                    r_loaded <= '0;
                end
            end
            if (r_state == S_ADDR && AWREADY) AWVALID <= 1'b0;
            if (w_data_hs) begin
                WDATA    <= wr_data;
                WVALID   <= 1'b1;
                WLAST    <= (r_loaded == {1'b0, AWLEN});
                r_loaded <= r_loaded + 9'd1;
            end else if (w_beat_ret) begin
                WVALID <= 1'b0;
            end
            // the last beat is loaded only once, so no new word can arrive alongside its retirement
            if (w_last_ret) begin
                WVALID <= 1'b0;
                WLAST  <= 1'b0;
                BREADY <= 1'b1;
            end
            if (r_state == S_RESP && BVALID) begin
                BREADY     <= 1'b0;
                done_valid <= 1'b1;
                done_resp  <= BRESP;
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_writer.sv
// tb_axi_burst_writer: directed plus randomized bursts against a transaction-level expectation
// (one AW record, the word list in order with a single final WLAST, one completion status).
module tb_axi_burst_writer;
    localparam int DW = 32;
    localparam int AW = 16;

    logic          ACLK = 1'b0;
    logic          ARESTN = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_data_valid = 1'b0;
    logic          wr_data_ready;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic          AWVALID;
    logic          AWREADY = 1'b0;
    logic [DW-1:0] WDATA;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY = 1'b0;
    logic [1:0]    BRESP = '0;
    logic          BVALID = 1'b0;
    logic          BREADY;

    axi_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESTN(ARESTN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .done_valid(done_valid), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    int vec = 0;
    int mis = 0;

    logic [AW+10:0] aw_log[$];
    logic [DW:0]    w_log[$];
    logic [1:0]     done_log[$];
    logic [DW-1:0]  src_q[$];
    int  n_data_hs, stall_viol, early_w, aw_cycles, w_cycles, br_cycles, done_dup, lat, done_lat;
    logic aw_done = 1'b1;
    logic hs_aw, hs_w, hs_d, hs_c, p_wstall, p_awstall, p_done;
    logic [DW-1:0]  p_wdata;
    logic           p_wlast;
    logic [AW+10:0] p_aw;

    int aw_stall = 0, w_mode = 0, b_delay = 0, aw_wait = 0, b_wait = 0;
    logic [1:0] b_resp = '0;
    bit src_rand = 0, w_tog = 0;

    // Observe everything at the falling edge, where both sides are settled for the next rising edge
    always @(negedge ACLK) begin
        if (!ARESTN) begin
            {hs_aw, hs_w, hs_d, hs_c, p_wstall, p_awstall, p_done} = '0;
            aw_done = 1'b1;
        end else begin
            hs_c  = cmd_valid & cmd_ready;
            hs_aw = AWVALID & AWREADY;
            hs_w  = WVALID & WREADY;
            hs_d  = wr_data_valid & wr_data_ready;
            if (p_wstall && (!WVALID || WDATA !== p_wdata || WLAST !== p_wlast)) stall_viol++;
            if (p_awstall && (!AWVALID || {AWADDR, AWLEN, AWSIZE} !== p_aw)) stall_viol++;
            if (WVALID && !aw_done) early_w++;
            if (AWVALID) aw_cycles++;
            if (WVALID) w_cycles++;
            if (BREADY) br_cycles++;
            if (done_valid && p_done) done_dup++;
            if (done_valid) begin
                done_log.push_back(done_resp);
                done_lat = lat;
            end
            lat = hs_c ? 1 : lat + 1;
            if (hs_aw) begin
                aw_log.push_back({AWADDR, AWLEN, AWSIZE});
                aw_done = 1'b1;
            end
            if (hs_w) w_log.push_back({WLAST, WDATA});
            if (hs_d) n_data_hs++;
            if (hs_c) aw_done = 1'b0;
            p_wstall  = WVALID & !WREADY;
            p_wdata   = WDATA;
            p_wlast   = WLAST;
            p_awstall = AWVALID & !AWREADY;
            p_aw      = {AWADDR, AWLEN, AWSIZE};
            p_done    = done_valid;
        end
    end

    // Word source and slave responder, updated just after each rising edge
    always @(posedge ACLK) begin
        #1;
        if (!ARESTN) begin
            {AWREADY, WREADY, BVALID, wr_data_valid} = '0;
            aw_wait = 0;
            b_wait  = 0;
        end else begin
            if (hs_c) cmd_valid = 1'b0;
            if (hs_d && src_q.size() > 0) void'(src_q.pop_front());
            wr_data_valid = src_q.size() > 0 && (!src_rand || $urandom_range(3) != 0);
            wr_data       = src_q.size() > 0 ? src_q[0] : '0;
            if (AWVALID) begin
                AWREADY = aw_wait >= aw_stall;
                aw_wait++;
            end else begin
                AWREADY = 1'b0;
                aw_wait = 0;
            end
            w_tog  = !w_tog;
            WREADY = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? w_tog : ($urandom_range(2) != 0);
            if (BREADY) begin
                BVALID = b_wait >= b_delay;
                b_wait++;
            end else begin
                BVALID = 1'b0;
                b_wait = 0;
            end
            BRESP = BVALID ? b_resp : 2'b00;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        aw_log.delete();
        w_log.delete();
        done_log.delete();
        src_q.delete();
        {n_data_hs, stall_viol, early_w, aw_cycles, w_cycles, br_cycles, done_dup} = '0;
        done_lat = -1;
    endtask

    // base==0 selects random words, otherwise words are base, base+1, ...
    task automatic burst(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] resp, input logic [DW-1:0] base);
        logic [DW-1:0] d[$];
        logic [1:0]    exp_resp;
        bit            legal;
        int            n, cyc, bad;
        @(posedge ACLK);
        #2;
        clear_logs();
        n        = int'(l) + 1;
        legal    = s <= 3'd2;
        exp_resp = legal ? resp : 2'b10;
        b_resp   = resp;
        for (int i = 0; i < n; i++) d.push_back(base == 0 ? DW'($urandom) : base + DW'(i));
        foreach (d[i]) src_q.push_back(d[i]);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_valid = 1'b1;
        cyc = 0;
        while (done_log.size() == 0 && cyc < 3000) begin
            @(posedge ACLK);
            cyc++;
        end
        repeat (3) @(posedge ACLK);
        #2;
        check("done_count", 64'(done_log.size()), 64'd1);
        check("done_resp", done_log.size() > 0 ? 64'(done_log[0]) : 64'hx, 64'(exp_resp));
        check("aw_count", 64'(aw_log.size()), legal ? 64'd1 : 64'd0);
        if (aw_log.size() > 0) check("aw_fields", 64'(aw_log[0]), 64'({a, l, s}));
        check("w_count", 64'(w_log.size()), legal ? 64'(n) : 64'd0);
        bad = 0;
        for (int i = 0; i < n && i < w_log.size(); i++)
            if (w_log[i] !== {i == n - 1, d[i]}) bad++;
        check("w_beats_wrong", 64'(bad), 64'd0);
        check("wr_data_hs", 64'(n_data_hs), legal ? 64'(n) : 64'd0);
        check("protocol", 64'({stall_viol[15:0], early_w[15:0], done_dup[15:0]}), 64'd0);
    endtask

    initial begin
        #1 ARESTN = 1'b0;
        #3;
        check("rst_ctl", 64'({AWVALID, WVALID, WLAST, BREADY, done_valid, cmd_ready, wr_data_ready}), 64'd0);
        check("rst_data", 64'({AWADDR, AWLEN, AWSIZE, done_resp}), 64'd0);
        check("rst_wdata", 64'(WDATA), 64'd0);
        repeat (2) @(posedge ACLK);
        #3 ARESTN = 1'b1;
        check("cmd_ready_pre_edge", 64'(cmd_ready), 64'd0);
        @(posedge ACLK);
        #2 check("cmd_ready_post_edge", 64'(cmd_ready), 64'd1);

        w_mode = 0; src_rand = 0; aw_stall = 0; b_delay = 0;
        burst(16'h0010, 8'd0, 3'd2, 2'b00, 32'hDEADBEEF);
        check("t1_aw_cycles", 64'(aw_cycles), 64'd1);

        w_mode = 1;
        burst(16'h0100, 8'd3, 3'd2, 2'b00, 32'd1);

        w_mode = 0; aw_stall = 5;
        burst(16'h2468, 8'd2, 3'd1, 2'b01, 32'd0);
        check("t3_aw_cycles", 64'(aw_cycles), 64'd6);

        aw_stall = 0; b_delay = 3;
        burst(16'h1000, 8'd1, 3'd2, 2'b10, 32'd0);
        check("t4_bready_cycles", 64'(br_cycles), 64'd4);

        b_delay = 0;
        burst(16'h3000, 8'd0, 3'd3, 2'b00, 32'd0);
        check("t5_aw_cycles", 64'(aw_cycles), 64'd0);
        check("t5_done_latency", 64'(done_lat), 64'd1);

        burst(16'h4000, 8'd15, 3'd2, 2'b00, 32'd0);
        check("zero_bubble_w_cycles", 64'(w_cycles), 64'd16);

        for (int k = 0; k < 6; k++) begin
            w_mode   = $urandom_range(2);
            src_rand = 1;
            aw_stall = $urandom_range(3);
            b_delay  = $urandom_range(4);
            burst(AW'($urandom), 8'($urandom_range(31)), 3'($urandom_range(3)), 2'($urandom_range(3)), 32'd0);
        end

        w_mode = 2; src_rand = 1; aw_stall = 0; b_delay = 1;
        burst(16'h8000, 8'd255, 3'd2, 2'b00, 32'd0);
        burst(16'h9000, 8'd255, 3'd0, 2'b11, 32'd0);

        @(posedge ACLK);
        #2;
        clear_logs();
        w_mode = 0; src_rand = 0;
        for (int i = 0; i < 256; i++) src_q.push_back(DW'(i));
        cmd_addr = 16'hA000; cmd_len = 8'd255; cmd_size = 3'd2; cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 1000 && w_log.size() < 40; cyc++) @(posedge ACLK);
        check("rst_mid_streaming", 64'(w_log.size() >= 40), 64'd1);
        #3 ARESTN = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({AWVALID, WVALID, WLAST, BREADY, done_valid, cmd_ready, wr_data_ready}), 64'd0);
        repeat (3) @(posedge ACLK);
        #3 ARESTN = 1'b1;
        src_q.delete();
        done_log.delete();
        @(posedge ACLK);
        #2 check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (5) @(posedge ACLK);
        #2 check("rst_mid_no_done", 64'(done_log.size()), 64'd0);

        w_mode = 1; src_rand = 1;
        burst(16'hB004, 8'd7, 3'd2, 2'b01, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
